moving_avg_stereo: RTL and testbench
====================================

# moving_avg_stereo

Parametrised stereo moving-average (boxcar FIR) filter for the audio path, placed between the codec sample-capture logic and the output/DAC path. It generalises the fixed 8-tap mono averager: tap count is a power of two, left and right are filtered independently in lockstep, and a valid/ready handshake with output backpressure is added. It uses a circular sample buffer with an exact running sum, so cost per sample is one add and one subtract regardless of depth.

## Interface
- DATA_WIDTH, 24: signed sample width per channel.
- LOG2_N, 3: log2 of tap count N; legal range 1..8.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush of history, active-high.
- in_valid  in  1  input sample pair present.
- in_ready  out  1  block can accept a pair this cycle.
- left_in  in  DATA_WIDTH  signed left sample.
- right_in  in  DATA_WIDTH  signed right sample.
- out_valid  out  1  output pair present.
- out_ready  in  1  downstream accepts output this cycle.
- left_out  out  DATA_WIDTH  signed left average.
- right_out  out  DATA_WIDTH  signed right average.
- primed  out  1  N samples accepted since last reset/clear.

## Operation
- Per channel: buffer of N DATA_WIDTH entries, write pointer wptr (LOG2_N bits, shared), running sum of DATA_WIDTH+LOG2_N bits; fill counter 0..N shared, saturating.
- Accept = in_valid && in_ready.
- On accept, per channel: sum <= sum + x - buf[wptr]; buf[wptr] <= x; wptr <= wptr+1 mod N (natural wrap); fill <= min(fill+1, N).
- Output on accept: out <= (sum + x - buf[wptr]) >>> LOG2_N (arithmetic shift, floor toward -inf). Result always fits DATA_WIDTH; no saturation needed.
- Warm-up: buffer is zero after reset/clear, so the first N-1 outputs average the new samples with zeros (k-th output = sum of k samples / N).
- primed = (fill == N).
- in_ready = !clear && (!out_valid || out_ready).
- Output register: set out_valid on accept; clear out_valid when out_valid && out_ready && no accept the same cycle. left_out/right_out change only on accept.
- clear: zeros buffers, sums, wptr, fill, out_valid next cycle; left_out/right_out hold their last values. An in_valid during clear is not accepted (in_ready low).
- Reset: all of the above plus left_out = right_out = 0.

## Timing
- Reset values: in_ready 1 (after reset deasserts), out_valid 0, left_out 0, right_out 0, primed 0.
- Latency: sample accepted at edge k → out_valid high, corresponding average on outputs after edge k (one cycle).
- Throughput: one pair per cycle when out_ready is held high.
- Backpressure: while out_valid && !out_ready, in_ready is 0 and outputs are stable.
- Simultaneous pop and accept: the new average replaces the old one and out_valid stays 1.
- Reset or clear asserted mid-stream takes effect at the next edge and overrides any accept. Reset has priority over clear.

## Configuration
- MOVAVG_ROUND_EN defined: output = (sum_next + 2^(LOG2_N-1)) >>> LOG2_N (round half up). The adder is one bit wider to avoid overflow, and the result is clamped to the DATA_WIDTH signed maximum.
- Undefined: plain arithmetic shift (floor), with no rounding adder.

## Test plan
- Reset: assert reset 2 cycles → out_valid 0, outputs 0, primed 0, and in_ready 1 in the first cycle after release.
- Ramp-up: N=8, feed left=800 and right=-800 for 8 cycles with out_ready=1 → left 100,200,…,800, right -100,…,-800; primed goes high with the 8th output.
- Rounding: after reset, feed left=-1 once → left_out -1 without MOVAVG_ROUND_EN, 0 with it; left=4 → 0 and 1 respectively.
- Wrap/steady state: feed left=8·i for i=1..16 → 9th output 44 and 16th output 100 (window 9..16), with no glitch at the wptr wrap; eight samples of 24'h7FFFFF → 24'h7FFFFF, with no overflow.
- Backpressure: drop out_ready for 3 cycles with in_valid high → outputs frozen, in_ready 0, no samples lost; after out_ready rises, the stream resumes with the correct sums.
- Clear mid-stream: after 5 samples of 800, pulse clear with in_valid high → that sample is dropped, out_valid 0, primed 0; the next 800 gives 100.

Source files
------------

// File: rtl/moving_avg_stereo.sv
// rtl/moving_avg_stereo.sv - stereo power-of-two boxcar moving-average filter with valid/ready handshake
//
// Purpose:
//   Averages the last N = 2**LOG2_N samples of each channel. Left and right
//   share the write pointer and fill counter and advance in lockstep. Each
//   channel keeps a circular history buffer and an exact running sum, so one
//   accepted sample costs one add and one subtract per channel.
//
// Build option:
//   MOVAVG_ROUND_EN - when defined, the average is rounded half up and
//                     clamped to the signed maximum. When undefined, the
//                     average is floored (arithmetic shift).
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset (also zeroes the outputs)
//   clear      synchronous flush of history; outputs hold their last values
//   in_valid   input sample pair present
//   in_ready   block can accept a pair this cycle
//   left_in    signed left sample
//   right_in   signed right sample
//   out_valid  output pair present
//   out_ready  downstream accepts the output this cycle
//   left_out   signed left average
//   right_out  signed right average
//   primed     N samples accepted since the last reset/clear

module moving_avg_stereo #(
    parameter int DATA_WIDTH = 24,
    parameter int LOG2_N     = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] left_in,
    input  logic signed [DATA_WIDTH-1:0] right_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] left_out,
    output logic signed [DATA_WIDTH-1:0] right_out,
    output logic                         primed
);

    localparam int N  = 1 << LOG2_N;
    localparam int SW = DATA_WIDTH + LOG2_N;   // running-sum width: N full-scale samples fit exactly

    localparam logic [LOG2_N:0] FILL_FULL = (LOG2_N + 1)'(N);

`ifdef MOVAVG_ROUND_EN
    localparam logic signed [SW:0]           HALF    = (SW + 1)'(N / 2);
    localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
`endif

    // Sign-extend a sample to running-sum width.
    function automatic logic signed [SW-1:0] widen(input logic signed [DATA_WIDTH-1:0] x);
        return {{LOG2_N{x[DATA_WIDTH-1]}}, x};
    endfunction

    // Divide a running sum by N.
    function automatic logic signed [DATA_WIDTH-1:0] average(input logic signed [SW-1:0] s);
`ifdef MOVAVG_ROUND_EN
        logic signed [SW:0]       wide;
        logic        [DATA_WIDTH:0] q;
        // One extra bit so adding the half-LSB cannot wrap a full-scale sum.
        wide = $signed({s[SW-1], s}) + HALF;
        q    = (DATA_WIDTH + 1)'(wide >>> LOG2_N);
        // Rounding only moves the result upwards, so only the positive
        // limit can be exceeded.
        if (!q[DATA_WIDTH] && q[DATA_WIDTH-1]) begin
            return OUT_MAX;
        end
        return $signed(q[DATA_WIDTH-1:0]);
`else
        return DATA_WIDTH'(s >>> LOG2_N);
`endif
    endfunction

    logic signed [DATA_WIDTH-1:0] hist_l [N];
    logic signed [DATA_WIDTH-1:0] hist_r [N];
    logic signed [SW-1:0]         sum_l;
    logic signed [SW-1:0]         sum_r;
    logic        [LOG2_N-1:0]     wptr;
    logic        [LOG2_N:0]       fill;

    logic                         accept;
    logic signed [DATA_WIDTH-1:0] oldest_l;
    logic signed [DATA_WIDTH-1:0] oldest_r;
    logic signed [SW-1:0]         sum_next_l;
    logic signed [SW-1:0]         sum_next_r;

    // A full output register stalls the input unless it is drained in the
    // same cycle; clear always blocks the input so the flush is clean.
    assign in_ready = !clear && (!out_valid || out_ready);
    assign primed   = (fill == FILL_FULL);

    always_comb begin
        accept     = in_valid && in_ready;
        oldest_l   = hist_l[wptr];
        oldest_r   = hist_r[wptr];
        // The entry at wptr is the sample leaving the window.
        sum_next_l = sum_l + widen(left_in)  - widen(oldest_l);
        sum_next_r = sum_r + widen(right_in) - widen(oldest_r);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                hist_l[i] <= '0;
                hist_r[i] <= '0;
            end
            sum_l     <= '0;
            sum_r     <= '0;
            wptr      <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            left_out  <= '0;
            right_out <= '0;
        end else if (clear) begin
            // Output data registers deliberately keep their last values.
            for (int i = 0; i < N; i++) begin
                hist_l[i] <= '0;
                hist_r[i] <= '0;
            end
            sum_l     <= '0;
            sum_r     <= '0;
            wptr      <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            hist_l[wptr] <= left_in;
            hist_r[wptr] <= right_in;
            sum_l        <= sum_next_l;
            sum_r        <= sum_next_r;
            wptr         <= wptr + LOG2_N'(1);
            if (fill != FILL_FULL) begin
                fill <= fill + (LOG2_N + 1)'(1);
            end
            // Accept with a simultaneous pop simply replaces the result.
            out_valid <= 1'b1;
            left_out  <= average(sum_next_l);
            right_out <= average(sum_next_r);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_moving_avg_stereo.sv
// tb/tb_moving_avg_stereo.sv - directed self-checking bench for moving_avg_stereo (N = 8)

module tb_moving_avg_stereo;

    localparam int DW = 24;
    localparam int LN = 3;

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b1;
    logic                 clear     = 1'b0;
    logic                 in_valid  = 1'b0;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] left_in   = '0;
    logic signed [DW-1:0] right_in  = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic signed [DW-1:0] left_out;
    logic signed [DW-1:0] right_out;
    logic                 primed;

    int checks   = 0;
    int failures = 0;

    moving_avg_stereo #(
        .DATA_WIDTH(DW),
        .LOG2_N    (LN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .left_in  (left_in),
        .right_in (right_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .left_out (left_out),
        .right_out(right_out),
        .primed   (primed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input int l, input int r);
        left_in  = l[DW-1:0];
        right_in = r[DW-1:0];
        in_valid = 1'b1;
        tick();
    endtask

    initial begin
        int ws;

        // Reset state
        do_reset();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_left_out", left_out, 0);
        check("rst_right_out", right_out, 0);
        check("rst_primed", 32'(primed), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // Ramp-up: 800 / -800 for eight samples
        for (int k = 1; k <= 8; k++) begin
            push(800, -800);
            check("ramp_left", left_out, 100 * k);
            check("ramp_right", right_out, -100 * k);
            check("ramp_valid", 32'(out_valid), 1);
            check("ramp_primed", 32'(primed), (k == 8) ? 1 : 0);
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(out_valid), 0);
        check("drain_hold_left", left_out, 800);

        // Rounding of small values
        do_reset();
        push(-1, 0);
`ifdef MOVAVG_ROUND_EN
        check("round_neg1", left_out, 0);
`else
        check("round_neg1", left_out, -1);
`endif
        do_reset();
        push(4, 0);
`ifdef MOVAVG_ROUND_EN
        check("round_4", left_out, 1);
`else
        check("round_4", left_out, 0);
`endif

        // Wrap / steady state: left = 8*i, window sum of i equals the average
        do_reset();
        ws = 0;
        for (int i = 1; i <= 16; i++) begin
            ws += i;
            if (i > 8) ws -= i - 8;
            push(8 * i, -8 * i);
            check($sformatf("wrap_left_%0d", i), left_out, ws);
            check($sformatf("wrap_right_%0d", i), right_out, -ws);
        end
        for (int k = 1; k <= 8; k++) begin
            push(8388607, -8388608);
        end
        check("fullscale_left", left_out, 8388607);
        check("fullscale_right", right_out, -8388608);
        check("fullscale_primed", 32'(primed), 1);

        // Backpressure
        do_reset();
        push(800, -800);
        push(800, -800);
        check("bp_pre_left", left_out, 200);
        out_ready = 1'b0;
        left_in   = 24'sd800;
        right_in  = -24'sd800;
        in_valid  = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("bp_in_ready", 32'(in_ready), 0);
            tick();
            check("bp_frozen_left", left_out, 200);
            check("bp_frozen_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        for (int k = 3; k <= 8; k++) begin
            push(800, -800);
            check("bp_resume_left", left_out, 100 * k);
            check("bp_resume_right", right_out, -100 * k);
        end
        check("bp_primed", 32'(primed), 1);

        // Clear mid-stream
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            push(800, -800);
        end
        check("clr_pre_left", left_out, 500);
        clear = 1'b1;
        #1;
        check("clr_in_ready", 32'(in_ready), 0);
        tick();
        clear = 1'b0;
        check("clr_out_valid", 32'(out_valid), 0);
        check("clr_primed", 32'(primed), 0);
        check("clr_hold_left", left_out, 500);
        push(800, -800);
        check("clr_next_left", left_out, 100);
        check("clr_next_right", right_out, -100);
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
